ho_key_seq_unlock: RTL and testbench

- Parametrised successor of the single-key user-unlock path in the obfuscation top level.
- Accepts a sequence of NUM_KEYS user keys. Each key arrives with its own seed/IV pair and is masked by an LFSR keystream.
- Each masked key is compared against a stored expected value; the design unlocks only after the full sequence matches in order.
- Adds a failure counter with lockout, and relock/clear on reseed. Sits between the user key interface and the obfuscated AES datapath enable.

---
 rtl/ho_key_seq_unlock.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ho_key_seq_unlock.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ho_key_seq_unlock.sv
// ho_key_seq_unlock
//
// Multi-key user unlock sequencer sitting between the user key interface and the
// obfuscated AES datapath enable.
//
// Each accepted request latches Key together with Ukey_seed ^ User_IV. That value seeds
// a SEED_W-bit Fibonacci LFSR; an all-zero seed is replaced by 1 so the LFSR cannot lock
// up. The LFSR is clocked WARMUP times with its output thrown away, then KEY_W more
// times. Those KEY_W output bits are captured MSB first as the keystream ks. The masked
// key (Key ^ ks) must equal exp_keys slot seq_idx.
//
// NUM_KEYS matches in a row unlock the design until reseed or RST. MAX_FAIL mismatches
// in a row lock it out until reseed or RST. reseed relocks, clears the counters and
// aborts any check in flight.
//
// Optional feature, enabled by defining HO_SEQ_TIMEOUT_EN:
//   While the FSM waits in IDLE partway through a sequence (seq_idx != 0), a counter
//   runs. After TIMEOUT cycles without a request, seq_idx rewinds to 0.
//
// Ports:
//   CLK            clock
//   RST            synchronous active-high reset
//   Key_ready_user key request strobe (only honoured in IDLE, and only when reseed=0)
//   Key            user key
//   Ukey_seed      per-key seed
//   User_IV        per-key IV
//   exp_keys       expected masked keys; slot i at [i*KEY_W +: KEY_W]
//   reseed         relock, clear failures and lockout, abort any check in flight
//   busy           check in progress (LOAD, WARM, GEN, CHECK)
//   done           one-cycle pulse per completed check
//   pass           result of the last check; held until the next check or reseed
//   unlock         full sequence matched
//   locked_out     lockout active
//   seq_idx        index of the next expected key
//   fail_cnt       consecutive failure count (saturates at MAX_FAIL)

module ho_key_seq_unlock #(
    parameter int unsigned       KEY_W    = 64,
    parameter int unsigned       SEED_W   = 80,
    parameter int unsigned       NUM_KEYS = 2,
    parameter int unsigned       MAX_FAIL = 3,
    parameter int unsigned       WARMUP   = 160,
    parameter logic [SEED_W-1:0] POLY     = 80'hC000_0000_0600_0000_0000,
    parameter int unsigned       TIMEOUT  = 1024
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Key_ready_user,
    input  logic [KEY_W-1:0]          Key,
    input  logic [SEED_W-1:0]         Ukey_seed,
    input  logic [SEED_W-1:0]         User_IV,
    input  logic [NUM_KEYS*KEY_W-1:0] exp_keys,
    input  logic                      reseed,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      unlock,
    output logic                      locked_out,
    output logic [2:0]                seq_idx,
    output logic [3:0]                fail_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWarm,
        StGen,
        StCheck,
        StUnlocked,
        StLockout
    } state_e;

    // One counter is shared by the WARM and GEN phases, so it is sized for the longer one.
    localparam int unsigned CNT_MAX = (WARMUP > KEY_W) ? WARMUP : KEY_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  WARM_LAST  = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0]  GEN_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [2:0]        LAST_IDX   = 3'(NUM_KEYS - 1);
    localparam logic [3:0]        MAX_FAIL_C = 4'(MAX_FAIL);
    localparam logic [SEED_W-1:0] SEED_ONE   = SEED_W'(1);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [SEED_W-1:0]  mix_q, mix_d;      // latched Ukey_seed ^ User_IV
    logic [SEED_W-1:0]  lfsr_q, lfsr_d;
    logic [KEY_W-1:0]   ks_q, ks_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               unlock_q, unlock_d;
    logic               locked_q, locked_d;
    logic [2:0]         seq_q, seq_d;
    logic [3:0]         fail_q, fail_d;

    logic [SEED_W-1:0]  lfsr_step;
    logic [KEY_W-1:0]   exp_slot;
    logic               match;
    logic [3:0]         fail_inc;

`ifdef HO_SEQ_TIMEOUT_EN
    localparam int unsigned    TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Fibonacci step: shift left and feed the parity of the tapped bits into the LSB.
    // The output bit is lfsr_q[SEED_W-1], taken before the shift.
    assign lfsr_step = {lfsr_q[SEED_W-2:0], ^(lfsr_q & POLY)};

    always_comb begin
        exp_slot = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (seq_q == 3'(i)) begin
                exp_slot = exp_keys[i*KEY_W +: KEY_W];
            end
        end
    end

    assign match    = ((key_q ^ ks_q) == exp_slot);
    assign fail_inc = (fail_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        mix_d    = mix_q;
        lfsr_d   = lfsr_q;
        ks_d     = ks_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        unlock_d = unlock_q;
        locked_d = locked_q;
        seq_d    = seq_q;
        fail_d   = fail_q;
`ifdef HO_SEQ_TIMEOUT_EN
        tmo_d    = '0;
`endif

        if (reseed) begin
            // Takes priority over everything, including a request in the same cycle.
            state_d  = StIdle;
            pass_d   = 1'b0;
            unlock_d = 1'b0;
            locked_d = 1'b0;
            seq_d    = '0;
            fail_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Key_ready_user) begin
                        key_d   = Key;
                        mix_d   = Ukey_seed ^ User_IV;
                        state_d = StLoad;
                    end
`ifdef HO_SEQ_TIMEOUT_EN
                    else if (seq_q != '0) begin
                        if (tmo_q == TMO_LAST) begin
                            seq_d = '0;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
                    end
`endif
                end
                StLoad: begin
                    lfsr_d  = (mix_q == '0) ? SEED_ONE : mix_q;
                    cnt_d   = '0;
                    state_d = (WARMUP == 0) ? StGen : StWarm;
                end
                StWarm: begin
                    lfsr_d = lfsr_step;
                    if (cnt_q == WARM_LAST) begin
                        cnt_d   = '0;
                        state_d = StGen;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGen: begin
                    lfsr_d = lfsr_step;
                    ks_d   = {ks_q[KEY_W-2:0], lfsr_q[SEED_W-1]};
                    if (cnt_q == GEN_LAST) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StCheck: begin
                    done_d = 1'b1;
                    pass_d = match;
                    if (match) begin
                        fail_d = '0;
                        if (seq_q == LAST_IDX) begin
                            seq_d    = '0;
                            unlock_d = 1'b1;
                            state_d  = StUnlocked;
                        end else begin
                            seq_d   = seq_q + 3'd1;
                            state_d = StIdle;
                        end
                    end else begin
                        seq_d  = '0;
                        fail_d = fail_inc;
                        if (fail_inc == MAX_FAIL_C) begin
                            locked_d = 1'b1;
                            state_d  = StLockout;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                // Requests are ignored here; only reseed or RST leaves these states.
                StUnlocked, StLockout: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            key_q    <= '0;
            mix_q    <= '0;
            lfsr_q   <= '0;
            ks_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            seq_q    <= '0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            mix_q    <= mix_d;
            lfsr_q   <= lfsr_d;
            ks_q     <= ks_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            unlock_q <= unlock_d;
            locked_q <= locked_d;
            seq_q    <= seq_d;
            fail_q   <= fail_d;
        end
    end

`ifdef HO_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign busy       = (state_q == StLoad) || (state_q == StWarm) ||
                        (state_q == StGen)  || (state_q == StCheck);
    assign done       = done_q;
    assign pass       = pass_q;
    assign unlock     = unlock_q;
    assign locked_out = locked_q;
    assign seq_idx    = seq_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_ho_key_seq_unlock.sv
// Self-checking bench for ho_key_seq_unlock (default parameters).
// Fixed table of requests and reseeds, hand-written corner sequences, and a randomized
// phase checked against a sequence/keystream model computed from the unlock rules.
module tb_ho_key_seq_unlock;

    localparam int unsigned KW  = 64;
    localparam int unsigned SW  = 80;
    localparam int unsigned NK  = 2;
    localparam int unsigned MF  = 3;
    localparam int unsigned WU  = 160;
    localparam int unsigned TMO = 1024;
    localparam logic [SW-1:0] POLY = 80'hC000_0000_0600_0000_0000;
    localparam int LAT    = WU + KW + 3;  // edge (counted from the request edge) seeing done
    localparam int BUSY_N = WU + KW + 2;  // LOAD + WARM + GEN + CHECK cycles

    localparam logic [KW-1:0] K0   = 64'h5468617473206D79;
    localparam logic [KW-1:0] K1   = 64'h204B756E67204675;
    localparam logic [KW-1:0] KBAD = 64'h5468617473206D78;
    localparam logic [SW-1:0] S0   = 80'h0053A6F94C9FF24598EB;
    localparam logic [SW-1:0] S1   = 80'h9953A6F94C9FF24598EB;
    localparam logic [SW-1:0] IV0  = 80'h0D74DB42A91077DE45AC;
    localparam logic [SW-1:0] SZ   = 80'h1234_5678_9ABC_DEF0_1357;
    localparam logic [KW-1:0] KZ   = 64'hDEAD_BEEF_0BAD_F00D;

    logic CLK = 1'b0;
    logic RST, Key_ready_user, reseed;
    logic [KW-1:0] Key;
    logic [SW-1:0] Ukey_seed, User_IV;
    logic [NK*KW-1:0] exp_keys;
    logic busy, done, pass, unlock, locked_out;
    logic [2:0] seq_idx;
    logic [3:0] fail_cnt;

    ho_key_seq_unlock dut (
        .CLK            (CLK),
        .RST            (RST),
        .Key_ready_user (Key_ready_user),
        .Key            (Key),
        .Ukey_seed      (Ukey_seed),
        .User_IV        (User_IV),
        .exp_keys       (exp_keys),
        .reseed         (reseed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .unlock         (unlock),
        .locked_out     (locked_out),
        .seq_idx        (seq_idx),
        .fail_cnt       (fail_cnt)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int m_seq, m_fail;
    bit m_unlock, m_lock, m_pass;

    typedef struct {
        int            op;      // 0 = request, 1 = reseed pulse
        logic [KW-1:0] k;
        logic [SW-1:0] s;
        logic [SW-1:0] v;
        bit            e_done;
        bit            e_pass;
        logic [2:0]    e_seq;
        logic [3:0]    e_fail;
        bit            e_unl;
        bit            e_lock;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] rand80();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    // Keystream straight from the rules: seed^IV (zero forced to 1), WARMUP discarded
    // output bits, then KEY_W output bits placed MSB first.
    function automatic logic [KW-1:0] keystream(input logic [SW-1:0] s, input logic [SW-1:0] v);
        logic [SW-1:0] st;
        logic [KW-1:0] ks;
        st = s ^ v;
        ks = '0;
        if (st == '0) st = SW'(1);
        for (int i = 0; i < int'(WU); i++) st = {st[SW-2:0], ^(st & POLY)};
        for (int i = 0; i < int'(KW); i++) begin
            ks[KW-1-i] = st[SW-1];
            st = {st[SW-2:0], ^(st & POLY)};
        end
        return ks;
    endfunction

    task automatic model_clear();
        m_seq = 0; m_fail = 0; m_unlock = 0; m_lock = 0; m_pass = 0;
    endtask

    task automatic model_req(input logic [KW-1:0] k, input logic [SW-1:0] s,
                             input logic [SW-1:0] v, output bit e_done);
        bit hit;
        if (m_unlock || m_lock) begin
            e_done = 1'b0;
            return;
        end
        e_done = 1'b1;
        hit = ((k ^ keystream(s, v)) == exp_keys[m_seq*KW +: KW]);
        m_pass = hit;
        if (hit) begin
            m_fail = 0;
            if (m_seq == int'(NK) - 1) begin
                m_seq = 0;
                m_unlock = 1;
            end else begin
                m_seq++;
            end
        end else begin
            m_seq = 0;
            if (m_fail < int'(MF)) m_fail++;
            if (m_fail == int'(MF)) m_lock = 1;
        end
    endtask

    task automatic check_state(input string tag, input bit e_pass, input logic [2:0] e_seq,
                               input logic [3:0] e_fail, input bit e_unl, input bit e_lock);
        check({tag, ".pass"},       80'(pass),       80'(e_pass));
        check({tag, ".seq_idx"},    80'(seq_idx),    80'(e_seq));
        check({tag, ".fail_cnt"},   80'(fail_cnt),   80'(e_fail));
        check({tag, ".unlock"},     80'(unlock),     80'(e_unl));
        check({tag, ".locked_out"}, 80'(locked_out), 80'(e_lock));
    endtask

    // Issue one request; optionally poke Key_ready_user, reseed or RST at sample e.
    // Returns when done is seen or after a bounded number of cycles.
    task automatic run_req(input logic [KW-1:0] k, input logic [SW-1:0] s,
                           input logic [SW-1:0] v, input int poke_at, input int reseed_at,
                           input int rst_at, output bit saw, output int lat, output int bsy);
        @(negedge CLK);
        Key = k; Ukey_seed = s; User_IV = v; Key_ready_user = 1'b1;
        saw = 1'b0; lat = 0; bsy = 0;
        for (int e = 0; e < LAT + 20 && !saw; e++) begin
            @(negedge CLK);
            if (e == 0) begin
                // Inputs after latching must not affect the check
                Key = {$urandom(), $urandom()}; Ukey_seed = rand80(); User_IV = rand80();
            end
            if (busy) bsy++;
            if (done) begin
                saw = 1'b1;
                lat = e + 1;
            end
            Key_ready_user = (e == poke_at);
            reseed         = (e == reseed_at);
            RST            = (e == rst_at);
        end
        Key_ready_user = 1'b0; reseed = 1'b0; RST = 1'b0;
    endtask

    task automatic pulse_reseed();
        @(negedge CLK); reseed = 1'b1;
        @(negedge CLK); reseed = 1'b0;
    endtask

    logic [KW-1:0] slot0, slot1;
    logic [KW-1:0] rk[NK];
    logic [SW-1:0] rs[NK], rv[NK];
    bit saw, e_done;
    int lat, bsy, poke, idx;
    logic [KW-1:0] k;
    logic [SW-1:0] s, v;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; Key_ready_user = 1'b0; reseed = 1'b0;
        Key = '0; Ukey_seed = '0; User_IV = '0;
        slot0 = K0 ^ keystream(S0, IV0);
        slot1 = K1 ^ keystream(S1, IV0);
        exp_keys = {slot1, slot0};
        repeat (2) @(negedge CLK);
        check("rst.busy", 80'(busy), 80'(0));
        check("rst.done", 80'(done), 80'(0));
        check_state("rst", 0, 3'd0, 4'd0, 0, 0);
        RST = 1'b0;

        tbl[0]  = '{0, K0,   S0, IV0, 1, 1, 3'd1, 4'd0, 0, 0};
        tbl[1]  = '{0, K1,   S1, IV0, 1, 1, 3'd0, 4'd0, 1, 0};
        tbl[2]  = '{0, K0,   S0, IV0, 0, 1, 3'd0, 4'd0, 1, 0};
        tbl[3]  = '{1, '0,   '0, '0,  0, 0, 3'd0, 4'd0, 0, 0};
        tbl[4]  = '{0, KBAD, S0, IV0, 1, 0, 3'd0, 4'd1, 0, 0};
        tbl[5]  = '{0, KBAD, S0, IV0, 1, 0, 3'd0, 4'd2, 0, 0};
        tbl[6]  = '{0, KBAD, S0, IV0, 1, 0, 3'd0, 4'd3, 0, 1};
        tbl[7]  = '{0, KBAD, S0, IV0, 0, 0, 3'd0, 4'd3, 0, 1};
        tbl[8]  = '{1, '0,   '0, '0,  0, 0, 3'd0, 4'd0, 0, 0};
        tbl[9]  = '{0, K0,   S0, IV0, 1, 1, 3'd1, 4'd0, 0, 0};
        tbl[10] = '{0, K1,   S1, IV0, 1, 1, 3'd0, 4'd0, 1, 0};
        tbl[11] = '{1, '0,   '0, '0,  0, 0, 3'd0, 4'd0, 0, 0};
        tbl[12] = '{0, K0,   S0, IV0, 1, 1, 3'd1, 4'd0, 0, 0};
        tbl[13] = '{0, K0,   S0, IV0, 1, 0, 3'd0, 4'd1, 0, 0};
        tbl[14] = '{0, K0,   S0, IV0, 1, 1, 3'd1, 4'd0, 0, 0};
        tbl[15] = '{1, '0,   '0, '0,  0, 0, 3'd0, 4'd0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            if (tbl[i].op == 1) begin
                pulse_reseed();
            end else begin
                run_req(tbl[i].k, tbl[i].s, tbl[i].v, 50, -1, -1, saw, lat, bsy);
                check({tag, ".done"}, 80'(saw), 80'(tbl[i].e_done));
                if (tbl[i].e_done) begin
                    check({tag, ".latency"}, 80'(lat), 80'(LAT));
                    check({tag, ".busy_cycles"}, 80'(bsy), 80'(BUSY_N));
                end else begin
                    check({tag, ".busy_cycles"}, 80'(bsy), 80'(0));
                end
            end
            check_state(tag, tbl[i].e_pass, tbl[i].e_seq, tbl[i].e_fail, tbl[i].e_unl,
                        tbl[i].e_lock);
            @(negedge CLK);
            check({tag, ".done_pulse"}, 80'(done), 80'(0));
            check({tag, ".idle_busy"}, 80'(busy), 80'(0));
        end

        // reseed and request in the same cycle: request dropped
        @(negedge CLK); Key = K0; Ukey_seed = S0; User_IV = IV0;
        Key_ready_user = 1'b1; reseed = 1'b1;
        @(negedge CLK); Key_ready_user = 1'b0; reseed = 1'b0;
        check("reseed_wins.busy", 80'(busy), 80'(0));

        // Zero LFSR seed forces state 1
        exp_keys = {slot1, KZ ^ keystream(SZ, SZ)};
        run_req(KZ, SZ, SZ, -1, -1, -1, saw, lat, bsy);
        check("zero_seed.done", 80'(saw), 80'(1));
        check_state("zero_seed", 1, 3'd1, 4'd0, 0, 0);
        // reseed at GEN cycle 10 aborts the check
        run_req(K1, S1, IV0, -1, WU + 11, -1, saw, lat, bsy);
        check("abort.done", 80'(saw), 80'(0));
        check("abort.busy", 80'(busy), 80'(0));
        check("abort.busy_cycles", 80'(bsy), 80'(WU + 12));
        check_state("abort", 0, 3'd0, 4'd0, 0, 0);

        // Randomized sequences against the model
        for (int i = 0; i < int'(NK); i++) begin
            rk[i] = {$urandom(), $urandom()};
            rs[i] = rand80();
            rv[i] = rand80();
            exp_keys[i*KW +: KW] = rk[i] ^ keystream(rs[i], rv[i]);
        end
        pulse_reseed();
        model_clear();
        for (int it = 0; it < 30; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0 || ((m_unlock || m_lock) && r < 5)) begin
                pulse_reseed();
                model_clear();
                check_state("rnd_reseed", m_pass, 3'(m_seq), 4'(m_fail), m_unlock, m_lock);
            end else begin
                idx = m_seq;
                k = rk[idx]; s = rs[idx]; v = rv[idx];
                if ($urandom_range(0, 2) == 0) k = k ^ (64'd1 << $urandom_range(0, 63));
                if ($urandom_range(0, 5) == 0) s = rand80();
                poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 200)) : -1;
                model_req(k, s, v, e_done);
                run_req(k, s, v, poke, -1, -1, saw, lat, bsy);
                check("rnd.done", 80'(saw), 80'(e_done));
                if (saw && e_done) check("rnd.latency", 80'(lat), 80'(LAT));
                check_state("rnd", m_pass, 3'(m_seq), 4'(m_fail), m_unlock, m_lock);
                @(negedge CLK);
                check("rnd.idle_busy", 80'(busy), 80'(0));
            end
        end

        // Inter-key timeout behaviour
        exp_keys = {slot1, slot0};
        pulse_reseed();
        run_req(K0, S0, IV0, -1, -1, -1, saw, lat, bsy);
        check_state("tmo_key0", 1, 3'd1, 4'd0, 0, 0);
        repeat (1030) @(negedge CLK);
`ifdef HO_SEQ_TIMEOUT_EN
        check("tmo.seq_idx", 80'(seq_idx), 80'(0));
        run_req(K1, S1, IV0, -1, -1, -1, saw, lat, bsy);
        check("tmo_key1.done", 80'(saw), 80'(1));
        check_state("tmo_key1", 0, 3'd0, 4'd1, 0, 0);
`else
        check("notmo.seq_idx", 80'(seq_idx), 80'(1));
        run_req(K1, S1, IV0, -1, -1, -1, saw, lat, bsy);
        check("notmo_key1.done", 80'(saw), 80'(1));
        check_state("notmo_key1", 1, 3'd0, 4'd0, 1, 0);
`endif

        // RST mid-check aborts without done
        pulse_reseed();
        run_req(K0, S0, IV0, -1, -1, 100, saw, lat, bsy);
        check("rst_abort.done", 80'(saw), 80'(0));
        check("rst_abort.busy", 80'(busy), 80'(0));
        check_state("rst_abort", 0, 3'd0, 4'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
